// File: rtl/shift_unit_seq.sv
// Multi-cycle shift execution unit: one bit position per clock, valid/ready on both sides.
// Modes: logical right, arithmetic right, logical left, rotate right.
module shift_unit_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_shift,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_ASR = 2'b01,
    MODE_LSL = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  state_e           state_q;
  mode_e            mode_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] cnt_q;
  logic             shift_q;

  logic [WIDTH-1:0] step_data;
  logic             step_bit;

  // Single-position shift of the working register for the latched mode.
  always_comb begin
    step_data = data_q;
    step_bit  = data_q[0];
    unique case (mode_q)
      MODE_LSR: begin
        step_data = {1'b0, data_q[WIDTH-1:1]};
        step_bit  = data_q[0];
      end
      MODE_ASR: begin
        step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        step_bit  = data_q[0];
      end
      MODE_LSL: begin
        step_data = {data_q[WIDTH-2:0], 1'b0};
        step_bit  = data_q[WIDTH-1];
      end
      MODE_ROR: begin
        step_data = {data_q[0], data_q[WIDTH-1:1]};
        step_bit  = data_q[0];
      end
      default: begin
        step_data = data_q;
        step_bit  = data_q[0];
      end
    endcase
  end

  // Control FSM and datapath registers; the working register doubles as the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LSR;
      data_q  <= '0;
      cnt_q   <= '0;
      shift_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            cnt_q   <= in_amt;
            mode_q  <= mode_e'(in_mode);
            shift_q <= 1'b0;
            state_q <= (in_amt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          data_q  <= step_data;
          shift_q <= step_bit;
          cnt_q   <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;
  assign out_shift = shift_q;
  assign out_zero  = (data_q == '0);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq (WIDTH=8): modes, large amounts, backpressure, mid-op reset.
module tb_shift_unit_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AMT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_shift;
  logic             out_zero;

  int errors = 0;
  int checks = 0;

  shift_unit_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, check latency and result, then hand it off.
  task automatic do_op(input string tag, input logic [7:0] d, input logic [3:0] amt,
                       input logic [1:0] mode, input logic [7:0] exp_d,
                       input logic exp_s, input logic exp_z);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'(1));
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = amt;
    in_mode  = mode;
    step();
    // Post-accept input changes must not disturb the operation.
    in_valid = 1'b0;
    in_data  = ~d;
    in_amt   = ~amt;
    in_mode  = ~mode;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(amt));
    check({tag, "_data"}, 32'(out_data), 32'(exp_d));
    check({tag, "_shift"}, 32'(out_shift), 32'(exp_s));
    check({tag, "_zero"}, 32'(out_zero), 32'(exp_z));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_handoff"}, 32'({out_valid, in_ready}), 32'(2'b01));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = '0;
    out_ready = 1'b0;

    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_shift", 32'(out_shift), 32'(0));
    check("rst_out_zero", 32'(out_zero), 32'(1));
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'(1));

    do_op("lsr_80_3",  8'h80, 4'd3,  2'b00, 8'h10, 1'b0, 1'b0);
    do_op("asr_80_3",  8'h80, 4'd3,  2'b01, 8'hF0, 1'b0, 1'b0);
    do_op("asr_ff_7",  8'hFF, 4'd7,  2'b01, 8'hFF, 1'b1, 1'b0);
    do_op("asr_7f_15", 8'h7F, 4'd15, 2'b01, 8'h00, 1'b0, 1'b1);
    do_op("lsl_01_1",  8'h01, 4'd1,  2'b10, 8'h02, 1'b0, 1'b0);
    do_op("lsl_ff_8",  8'hFF, 4'd8,  2'b10, 8'h00, 1'b1, 1'b1);
    do_op("ror_01_1",  8'h01, 4'd1,  2'b11, 8'h80, 1'b1, 1'b0);
    do_op("ror_a5_8",  8'hA5, 4'd8,  2'b11, 8'hA5, 1'b1, 1'b0);
    do_op("ror_3c_0",  8'h3C, 4'd0,  2'b11, 8'h3C, 1'b0, 1'b0);
    do_op("lsr_f1_9",  8'hF1, 4'd9,  2'b00, 8'h00, 1'b0, 1'b1);

    // Backpressure: result 0x0F>>2 held while a new operand waits.
    in_valid = 1'b1; in_data = 8'h0F; in_amt = 4'd2; in_mode = 2'b00;
    step();
    in_data = 8'h55; in_amt = 4'd1; in_mode = 2'b10;
    step();
    step();
    check("bp_valid", 32'(out_valid), 32'(1));
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_data", 32'({out_valid, in_ready, out_shift, out_data}), 32'({3'b101, 8'h03}));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_handoff", 32'({out_valid, in_ready}), 32'(2'b01));
    step();
    in_valid = 1'b0;
    check("bp_accepted", 32'({out_valid, in_ready}), 32'(2'b00));
    step();
    check("bp_new_result", 32'({out_valid, out_shift, out_zero, out_data}), 32'({3'b100, 8'hAA}));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_new_handoff", 32'({out_valid, in_ready}), 32'(2'b01));

    // Reset mid-operation discards the work and returns to idle.
    in_valid = 1'b1; in_data = 8'hF0; in_amt = 4'd6; in_mode = 2'b00;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_busy", 32'({out_valid, in_ready}), 32'(2'b00));
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready_low", 32'(in_ready), 32'(0));
    step();
    check("mid_rst_state", 32'({out_valid, out_shift, out_zero, out_data}), 32'({3'b001, 8'h00}));
    rst_n = 1'b1;
    #1;
    check("mid_rst_idle", 32'(in_ready), 32'(1));
    step();
    check("mid_rst_no_pulse", 32'(out_valid), 32'(0));
    do_op("lsr_02_1", 8'h02, 4'd1, 2'b00, 8'h01, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Parametrised, multi-cycle successor to the team's combinational 8-bit right shifter.
- Accepts one WIDTH-bit operand, a shift amount and a mode over a valid/ready handshake, then shifts one bit position per clock.
- Modes: logical right, arithmetic right, logical left, rotate right.
- Presents the result, the last bit shifted out and a zero flag, held until the consumer takes them.
- Sits in the ALU datapath as the shift execution unit, where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- AMT_W, 4, shift-amount width; must satisfy 2**AMT_W >= WIDTH. Amounts >= WIDTH are legal.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operand/amt/mode valid.
- in_ready  output  1  unit idle and able to accept; forced 0 while rst_n is low.
- in_data  input  WIDTH  operand.
- in_amt  input  AMT_W  shift amount, unsigned.
- in_mode  input  2  00 LSR, 01 ASR, 10 LSL, 11 ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- out_shift  output  1  last bit shifted or rotated out; 0 when amount was 0.
- out_zero  output  1  1 when out_data == 0.

Behaviour:
- Reset: any rising edge with rst_n=0 forces the following, regardless of current state; an in-flight operation is discarded and no out_valid pulse occurs.
  - state to IDLE, counter to 0
  - out_valid=0, out_data=0, out_shift=0
  - out_zero=1 (combinational from out_data)
- States: IDLE, SHIFT, DONE. in_ready=1 only in IDLE with rst_n=1. out_valid=1 only in DONE.
- IDLE: on edge with in_valid=1, the unit accepts.
  - Loads data reg <= in_data, cnt <= in_amt, mode reg <= in_mode, out_shift <= 0.
  - Next state is DONE if in_amt==0, else SHIFT.
  - Otherwise the unit holds.
- SHIFT, each edge, one step per mode:
  - LSR: reg <= {0, reg[W-1:1]}, shift <= reg[0].
  - ASR: reg <= {reg[W-1], reg[W-1:1]}, shift <= reg[0].
  - LSL: reg <= {reg[W-2:0], 0}, shift <= reg[W-1].
  - ROR: reg <= {reg[0], reg[W-1:1]}, shift <= reg[0].
  - Each step also does cnt <= cnt-1. When cnt==1 at the edge, next state is DONE.
- Latency: if the accept edge is k and the amount is N, out_valid is high after edge k+N (N=0: after edge k). No pipelining; throughput is one operation per N+2 cycles minimum.
- Amounts >= WIDTH: no clamping; iterate N times.
  - LSR/LSL give 0.
  - ASR gives all sign bits.
  - ROR wraps modulo WIDTH.
  - out_shift is the bit removed in the final step.
- DONE: out_data/out_shift/out_zero are stable while out_valid=1. On edge with out_ready=1, go to IDLE.
- in_ready=0 in DONE, so there is no same-cycle accept on handoff. A new operand can be accepted on the edge after the result is taken, at the earliest.
- in_valid while busy is ignored, not queued. Inputs are sampled only on the accept edge; later changes to in_* have no effect.
- out_ready while not in DONE is ignored.
- No X on outputs after the first reset edge.

Test Plan:
- WIDTH=8, LSR: in_data=0x80, amt=3, mode=00 -> out_data=0x10, out_shift=0, out_zero=0; out_valid exactly 3 edges after the accept edge.
- ASR: 0x80, amt=3 -> 0xF0, out_shift=0. Then 0xFF, amt=7 -> 0xFF, out_shift=1. Then 0x7F, amt=15 -> 0x00, out_zero=1, out_shift=0.
- LSL: 0x01, amt=1 -> 0x02, out_shift=0. Then 0xFF, amt=8 -> 0x00, out_shift=1, out_zero=1.
- ROR: 0x01, amt=1 -> 0x80, out_shift=1. Then 0xA5, amt=8 -> 0xA5. Then 0x3C, amt=0 -> 0x3C, out_shift=0, out_valid after 1 edge.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with new data -> out_data stable and in_ready=0 throughout. The new operand is accepted on the edge after the out_ready=1 handoff, not before.
- Reset mid-op: accept 0xF0, amt=6, LSR; drive rst_n=0 for one edge at cycle 3 -> next cycle in IDLE, out_valid=0, out_data=0. A fresh op 0x02, amt=1, LSR then gives 0x01.
